// File: rtl/wb_stage_pkg.sv
// Shared write-back stage definitions: bus layout, CP0 addresses,
// exception codes and the exception vector.
package wb_stage_pkg;

  localparam int MS_TO_WS_BUS_WD = 121;

  localparam logic [31:0] EX_ENTRY = 32'hBFC0_0380;

  // CP0 register addresses, encoded as {rd, sel}
  localparam logic [7:0] CR_BADVADDR = 8'h40;
  localparam logic [7:0] CR_COUNT    = 8'h48;
  localparam logic [7:0] CR_COMPARE  = 8'h58;
  localparam logic [7:0] CR_STATUS   = 8'h60;
  localparam logic [7:0] CR_CAUSE    = 8'h68;
  localparam logic [7:0] CR_EPC      = 8'h70;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef struct packed {
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic [7:0]  cp0_addr;
    logic        ex;
    logic        bd;
    logic        eret;
    logic        syscall;
    logic        mfc0;
    logic        mtc0;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_ws_t;

  function automatic logic is_adex(
    input logic [4:0] code
  );
    return (code == EXC_ADEL) ||
           (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/wb_stage_cp0_regs.sv
// CP0 register file: Status/Cause/EPC/BadVAddr, Count/Compare timer.
// Ports: commit strobes (ex, eret, wen) in, rdata/epc/has_int out.
module wb_stage_cp0_regs
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex,
  input  logic        eret,
  input  logic [4:0]  excode,
  input  logic        bd,
  input  logic [31:0] pc,
  input  logic [31:0] badvaddr,
  input  logic        wen,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  input  logic [5:0]  ext_int,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic        has_int
);

  logic [7:0]  st_im;
  logic        st_exl;
  logic        st_ie;
  logic        ca_bd;
  logic        ca_ti;
  logic [7:0]  ca_ip;
  logic [4:0]  ca_exc;
  logic [31:0] bva;
  logic [31:0] count;
  logic [31:0] compare;
  logic        tick;

  logic w_count;
  logic w_compare;
  logic w_status;
  logic w_cause;
  logic w_epc;

  always_comb begin
    w_count   = 1'b0;
    w_compare = 1'b0;
    w_status  = 1'b0;
    w_cause   = 1'b0;
    w_epc     = 1'b0;
    if (wen) begin
      unique case (1'b1)
        addr == CR_COUNT:   w_count   = 1'b1;
        addr == CR_COMPARE: w_compare = 1'b1;
        addr == CR_STATUS:  w_status  = 1'b1;
        addr == CR_CAUSE:   w_cause   = 1'b1;
        addr == CR_EPC:     w_epc     = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick    <= 1'b0;
      count   <= '0;
      compare <= '0;
      ca_ti   <= 1'b0;
    end else begin
      tick <= ~tick;
      if (w_count)
        count <= wdata;
      else if (tick)
        count <= count + 32'd1;
      // a Compare write wins over a match
      if (w_compare) begin
        compare <= wdata;
        ca_ti   <= 1'b0;
      end else if (count == compare) begin
        ca_ti <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_im  <= '0;
      st_exl <= 1'b0;
      st_ie  <= 1'b0;
      ca_bd  <= 1'b0;
      ca_ip  <= '0;
      ca_exc <= '0;
      epc    <= '0;
      bva    <= '0;
    end else begin
      ca_ip[7:2] <= {ext_int[5] | ca_ti,
                     ext_int[4:0]};
      if (w_status) begin
        st_im  <= wdata[15:8];
        st_exl <= wdata[1];
        st_ie  <= wdata[0];
      end
      if (w_cause)
        ca_ip[1:0] <= wdata[9:8];
      if (w_epc)
        epc <= wdata;
      if (eret)
        st_exl <= 1'b0;
      if (ex) begin
        st_exl <= 1'b1;
        ca_exc <= excode;
        // nested exception keeps the first EPC/BD
        if (!st_exl) begin
          ca_bd <= bd;
          epc   <= bd ? pc - 32'd4 : pc;
        end
        if (is_adex(excode))
          bva <= badvaddr;
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      addr == CR_BADVADDR: rdata = bva;
      addr == CR_COUNT:    rdata = count;
      addr == CR_COMPARE:  rdata = compare;
      addr == CR_STATUS:
        rdata = {9'd0, 1'b1, 6'd0, st_im,
                 6'd0, st_exl, st_ie};
      addr == CR_CAUSE:
        rdata = {ca_bd, ca_ti, 14'd0, ca_ip,
                 1'b0, ca_exc, 2'd0};
      addr == CR_EPC:      rdata = epc;
      default: ;
    endcase
  end

  assign has_int = (|(ca_ip & st_im))
                 & st_ie & ~st_exl;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: pipeline register, commit/flush logic,
// regfile write and trace outputs; instantiates the CP0 block.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int          MS_TO_WS_BUS_WD = 121,
  parameter logic [31:0] EX_ENTRY = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ws_allowin,
  input  logic        ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [5:0]  ext_int,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [4:0]  WB_dest,
  output logic [31:0] WB_result,
  output logic        ws_ex,
  output logic        ws_eret,
  output logic [31:0] ws_flush_pc,
  output logic        has_int,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  logic        ws_valid;
  logic        ws_ready_go;
  logic [MS_TO_WS_BUS_WD-1:0] bus_r;
  ms_ws_t      ws;
  logic        mtc0_we;
  logic [31:0] cp0_rdata;
  logic [31:0] cp0_epc;
  logic        unused_ok;

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = ~ws_valid | ws_ready_go;

  always_ff @(posedge clk) begin
    if (reset)
      ws_valid <= 1'b0;
    else if (ws_allowin)
      ws_valid <= ms_to_ws_valid;
  end

  always_ff @(posedge clk) begin
    if (reset)
      bus_r <= '0;
    else if (ws_allowin && ms_to_ws_valid)
      bus_r <= ms_to_ws_bus;
  end

  assign ws = ms_ws_t'(bus_r);

  assign ws_ex   = ws_valid & ws.ex;
  assign ws_eret = ws_valid & ws.eret & ~ws.ex;
  assign mtc0_we = ws_valid & ws.mtc0 & ~ws.ex;

  wb_stage_cp0_regs u_cp0 (
    .clk      (clk),
    .reset    (reset),
    .ex       (ws_ex),
    .eret     (ws_eret),
    .excode   (ws.excode),
    .bd       (ws.bd),
    .pc       (ws.pc),
    .badvaddr (ws.badvaddr),
    .wen      (mtc0_we),
    .addr     (ws.cp0_addr),
    .wdata    (ws.result),
    .ext_int  (ext_int),
    .rdata    (cp0_rdata),
    .epc      (cp0_epc),
    .has_int  (has_int)
  );

  assign ws_flush_pc = ws_ex ? EX_ENTRY
                             : cp0_epc;

  assign rf_we    = ws_valid & ws.gr_we & ~ws.ex;
  assign rf_waddr = ws.dest;
  assign rf_wdata = ws.mfc0 ? cp0_rdata
                            : ws.result;

  assign WB_dest   = rf_we ? ws.dest : 5'd0;
  assign WB_result = rf_wdata;

  assign debug_wb_pc       = ws.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = ws.dest;
  assign debug_wb_rf_wdata = rf_wdata;

  assign unused_ok = ws.syscall;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: commit, exceptions, ERET,
// CP0 access, timer interrupt and reset.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [120:0] ms_to_ws_bus;
  logic [5:0]  ext_int;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  WB_dest;
  logic [31:0] WB_result;
  logic        ws_ex;
  logic        ws_eret;
  logic [31:0] ws_flush_pc;
  logic        has_int;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] rd;

  wb_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ext_int           (ext_int),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .WB_dest           (WB_dest),
    .WB_result         (WB_result),
    .ws_ex             (ws_ex),
    .ws_eret           (ws_eret),
    .ws_flush_pc       (ws_flush_pc),
    .has_int           (has_int),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  function automatic ms_ws_t f_alu(
    input logic [4:0]  d,
    input logic [31:0] r
  );
    ms_ws_t b = '0;
    b.gr_we  = 1'b1;
    b.dest   = d;
    b.result = r;
    b.pc     = 32'hBFC0_0010;
    return b;
  endfunction

  function automatic ms_ws_t f_mfc0(
    input logic [7:0] a
  );
    ms_ws_t b = '0;
    b.mfc0     = 1'b1;
    b.gr_we    = 1'b1;
    b.dest     = 5'd2;
    b.cp0_addr = a;
    return b;
  endfunction

  function automatic ms_ws_t f_mtc0(
    input logic [7:0]  a,
    input logic [31:0] d
  );
    ms_ws_t b = '0;
    b.mtc0     = 1'b1;
    b.cp0_addr = a;
    b.result   = d;
    return b;
  endfunction

  function automatic ms_ws_t f_exc(
    input logic [4:0]  c,
    input logic [31:0] p,
    input logic        bdi,
    input logic [31:0] va
  );
    ms_ws_t b = '0;
    b.ex       = 1'b1;
    b.excode   = c;
    b.pc       = p;
    b.bd       = bdi;
    b.badvaddr = va;
    b.gr_we    = 1'b1;
    b.dest     = 5'd3;
    b.syscall  = (c == EXC_SYS);
    return b;
  endfunction

  function automatic ms_ws_t f_eret();
    ms_ws_t b = '0;
    b.eret = 1'b1;
    b.pc   = 32'hBFC0_0400;
    return b;
  endfunction

  // drive one instruction; returns #1 into its commit cycle
  task automatic issue(input ms_ws_t b);
    @(negedge clk);
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = b;
    @(posedge clk);
    #1;
    ms_to_ws_valid = 1'b0;
  endtask

  task automatic rd_cp0(
    input  logic [7:0]  a,
    output logic [31:0] d
  );
    issue(f_mfc0(a));
    d = rf_wdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;
    ext_int        = 6'b000001;
    idle(3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_ex", {31'd0, ws_ex}, 32'd0);
    chk("rst_dest", {27'd0, WB_dest}, 32'd0);
    chk("rst_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
    chk("rst_allowin", {31'd0, ws_allowin}, 32'd1);

    issue(f_alu(5'd5, 32'h1234));
    chk("alu_we", {31'd0, rf_we}, 32'd1);
    chk("alu_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("alu_wdata", rf_wdata, 32'h1234);
    chk("alu_fwd", {27'd0, WB_dest}, 32'd5);
    chk("alu_dwen", {28'd0, debug_wb_rf_wen}, 32'hF);
    idle(1);
    chk("alu_gone", {27'd0, WB_dest}, 32'd0);

    issue(f_exc(EXC_SYS, 32'hBFC0_0100, 1'b0, '0));
    chk("sys_ex", {31'd0, ws_ex}, 32'd1);
    chk("sys_flush", ws_flush_pc, 32'hBFC0_0380);
    chk("sys_we", {31'd0, rf_we}, 32'd0);
    chk("sys_eret", {31'd0, ws_eret}, 32'd0);
    rd_cp0(CR_EPC, rd);
    chk("sys_epc", rd, 32'hBFC0_0100);
    rd_cp0(CR_CAUSE, rd);
    chk("sys_code", rd & 32'h7C, 32'h20);
    rd_cp0(CR_STATUS, rd);
    chk("sys_exl", rd, 32'h0040_0002);

    issue(f_eret());
    chk("eret1", {31'd0, ws_eret}, 32'd1);
    chk("eret1_pc", ws_flush_pc, 32'hBFC0_0100);
    rd_cp0(CR_STATUS, rd);
    chk("eret1_exl", rd, 32'h0040_0000);

    issue(f_exc(EXC_ADEL, 32'hBFC0_0204, 1'b1,
                32'h1001));
    chk("adel_ex", {31'd0, ws_ex}, 32'd1);
    rd_cp0(CR_EPC, rd);
    chk("adel_epc", rd, 32'hBFC0_0200);
    rd_cp0(CR_CAUSE, rd);
    chk("adel_cause", rd & 32'h8000_007C,
        32'h8000_0010);
    rd_cp0(CR_BADVADDR, rd);
    chk("adel_bva", rd, 32'h1001);

    issue(f_mtc0(CR_BADVADDR, 32'h55));
    rd_cp0(CR_BADVADDR, rd);
    chk("bva_ro", rd, 32'h1001);
    issue(f_mtc0(CR_CAUSE, 32'hFFFF_FFFF));
    rd_cp0(CR_CAUSE, rd);
    chk("cause_sw", rd & 32'h0000_037C,
        32'h0000_0310);
    issue(f_mtc0(CR_CAUSE, 32'h0));
    issue(f_mtc0(8'h08, 32'hABCD));
    rd_cp0(8'h08, rd);
    chk("unmapped", rd, 32'h0);

    issue(f_mtc0(CR_STATUS, 32'h0000_8001));
    rd_cp0(CR_STATUS, rd);
    chk("status_wr", rd, 32'h0040_8001);
    issue(f_mtc0(CR_COUNT, 32'd0));
    issue(f_mtc0(CR_COMPARE, 32'd10));
    // count written at the previous edge; IP7
    // cannot rise before 21 edges later
    idle(19);
    chk("tmr_early", {31'd0, has_int}, 32'd0);
    idle(3);
    chk("tmr_int", {31'd0, has_int}, 32'd1);
    rd_cp0(CR_CAUSE, rd);
    chk("tmr_cause", rd & 32'h4000_8400,
        32'h4000_8400);

    issue(f_eret());
    chk("eret2", {31'd0, ws_eret}, 32'd1);
    chk("eret2_pc", ws_flush_pc, 32'hBFC0_0200);
    idle(1);
    chk("eret2_int", {31'd0, has_int}, 32'd1);

    issue(f_exc(EXC_SYS, 32'hBFC0_0300, 1'b0, '0));
    idle(1);
    chk("exl_mask", {31'd0, has_int}, 32'd0);
    begin
      ms_ws_t b;
      b = f_exc(EXC_RI, 32'hBFC0_0404, 1'b1, '0);
      b.mtc0     = 1'b1;
      b.cp0_addr = CR_EPC;
      b.result   = 32'hDEAD_BEEF;
      issue(b);
    end
    chk("nest_flush", ws_flush_pc, 32'hBFC0_0380);
    rd_cp0(CR_EPC, rd);
    chk("nest_epc", rd, 32'hBFC0_0300);
    rd_cp0(CR_CAUSE, rd);
    chk("nest_cause", rd & 32'h8000_007C,
        32'h0000_0028);

    issue(f_mtc0(CR_COUNT, 32'd5));
    idle(2);
    rd_cp0(CR_COUNT, rd);
    chk("count_rd", rd, 32'd6);

    issue(f_mtc0(CR_STATUS, 32'hFFFF_FFFF));
    rd_cp0(CR_STATUS, rd);
    chk("status_ro", rd, 32'h0040_FF03);

    @(negedge clk);
    reset          = 1'b1;
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = f_alu(5'd7, 32'h77);
    @(posedge clk);
    #1;
    chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
    chk("mid_rst_dest", {27'd0, WB_dest}, 32'd0);
    ms_to_ws_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rd_cp0(CR_STATUS, rd);
    chk("mid_rst_st", rd, 32'h0040_0000);
    rd_cp0(CR_EPC, rd);
    chk("mid_rst_epc", rd, 32'h0);
    rd_cp0(CR_CAUSE, rd);
    chk("mid_rst_code", rd & 32'h8000_007C, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Final (write-back) pipeline stage of the 5-stage MIPS core. Consumes the memory stage's output bus and commits results to the register file. Owns the CP0 register set: exception/ERET commit, timer interrupt, MFC0/MTC0. Drives the flush/redirect signals that squash the younger stages.

## Interface
Parameters:
- MS_TO_WS_BUS_WD, 121, width of the incoming bus.
- EX_ENTRY, 32'hBFC0_0380, exception vector.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ws_allowin  out  1  stage can accept
- ms_to_ws_valid  in  1  upstream valid
- ms_to_ws_bus  in  121  fields, MSB→LSB:
  - excode[5]
  - badvaddr[32]
  - cp0_addr[8] = {rd, sel}
  - ex
  - bd
  - eret
  - syscall
  - mfc0
  - mtc0
  - gr_we
  - dest[5]
  - result[32] (MTC0 write data when mtc0)
  - pc[32]
- ext_int  in  6  hardware interrupt lines
- rf_we  out  1  regfile write enable
- rf_waddr  out  5  regfile write address
- rf_wdata  out  32  regfile write data
- WB_dest  out  5  forwarding dest; 0 when invalid or no write
- WB_result  out  32  forwarding data (= rf_wdata)
- ws_ex  out  1  exception committing this cycle
- ws_eret  out  1  ERET committing this cycle
- ws_flush_pc  out  32  redirect target
- has_int  out  1  pending enabled interrupt, to decode
- debug_wb_pc  out  32  trace: pc
- debug_wb_rf_wen  out  4  trace: write enable
- debug_wb_rf_wnum  out  5  trace: write register
- debug_wb_rf_wdata  out  32  trace: write data

## Operation
- **Pipeline**
  - ws_ready_go=1.
  - ws_allowin = !ws_valid | ws_ready_go.
  - On allowin: ws_valid<=ms_to_ws_valid; bus register loads only when ms_to_ws_valid.
- **Commit signals**
  - ws_ex = ws_valid & ex.
  - ws_eret = ws_valid & eret & !ex.
  - ws_flush_pc = ws_ex ? EX_ENTRY : EPC.
- **Register file**
  - rf_we = ws_valid & gr_we & !ex.
  - rf_waddr = dest.
  - rf_wdata = mfc0 ? cp0_rdata : result.
  - debug_wb_rf_wen = {4{rf_we}}.
- **CP0 registers** ({rd,sel}):
  - BadVAddr {8,0}: read-only.
  - Count {9,0}
  - Compare {11,0}
  - Status {12,0}: BEV[22] read-only =1; IM[15:8], EXL[1], IE[0] writable.
  - Cause {13,0}: BD[31], TI[30], IP[15:8], ExcCode[6:2]; only IP[9:8] writable.
  - EPC {14,0}
  - Unmapped addresses: read 0, writes ignored.
- **MTC0**: write on ws_valid & mtc0 & !ex.
- **Exception commit (ws_ex)**
  - EXL<=1.
  - Cause.ExcCode<=excode.
  - If EXL was 0: Cause.BD<=bd; EPC<= bd ? pc-4 : pc.
  - If excode is AdEL(4) or AdES(5): BadVAddr<=badvaddr.
- **ERET commit**: EXL<=0.
- **Interrupt sources**
  - Cause.IP[7:2] <= {ext_int[5]|TI, ext_int[4:0]} every cycle.
  - has_int = |(IP & IM) & IE & !EXL.
- **Timer**
  - Internal tick toggles each cycle; Count increments when tick=1 (every 2nd cycle).
  - Count==Compare sets TI.
  - MTC0 Compare clears TI.
- **Priority**
  - exception > MTC0 on the same instruction.
  - MTC0 Count overrides the increment.
  - MTC0 Compare (clear TI) overrides a match in the same cycle.

## Timing
- **Reset values**
  - ws_valid=0
  - Status=0x0040_0000
  - Cause, EPC, BadVAddr, Count, Compare = 0
  - tick=0
  - All outputs derived from ws_valid deasserted.
- ws_ex, ws_eret, rf_we and MFC0 reads are combinational within the commit cycle. CP0 updates land at the following edge.
- Latency: 1 cycle from accepting the bus to commit.
- Exception commit: ws_valid clears on the next edge when ms_to_ws_valid is 0, which the memory stage guarantees by gating on ws_ex/ws_eret.
- Reset mid-operation: all state returns to reset values next edge.

## Structure
- Shared header mycpu.h holds:
  - MS_TO_WS_BUS_WD
  - CP0 address constants (CR_STATUS, CR_CAUSE, ...)
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12)
  - EX_ENTRY
- Sub-module cp0_regs contains the CP0 register file, timer and has_int logic. wb_stage holds the pipeline register, commit logic and regfile/debug outputs.

## Test plan
- addu result 0x1234 to $5 → rf_we=1, waddr=5, wdata=0x1234; WB_dest=5 in the same cycle.
- Syscall at pc 0xBFC0_0100, bd=0 → ws_ex=1, ws_flush_pc=0xBFC0_0380, rf_we=0; next cycle EPC=0xBFC0_0100, ExcCode=8, EXL=1.
- AdEL in a delay slot at pc 0xBFC0_0204, badvaddr 0x1001 → EPC=0xBFC0_0200, BD=1, BadVAddr=0x1001, ExcCode=4.
- MTC0 Status 0x0000_8001, then MTC0 Compare 10 with Count written 0 → after 20 cycles TI=1, IP7=1, has_int=1; ERET → ws_flush_pc=EPC, EXL=0.
- Exception raised while EXL=1 → EPC and BD unchanged, ExcCode updated.
- MFC0 from Count two cycles after MTC0 Count=5 → wdata=6; reset asserted mid-stream → ws_valid=0 and Status=0x0040_0000.
